// File: rtl/aes_cipher_state_if.sv
// Bus between the AES wrapper/key schedule (master) and the forward-cipher datapath (slave).
// Byte arrays are column-major: element r+4c is row r, column c.
interface aes_cipher_state_if #(
  parameter int Nb = 4,
  parameter int Nr = 10
);
  logic [7:0]  SBox     [0:255];
  logic [31:0] KExp     [0:Nb*(Nr+1)-1];
  logic [7:0]  Data_in  [0:4*Nb-1];
  logic        Enable;
  logic        Ack_in;
  logic [7:0]  Data_out [0:4*Nb-1];
  logic        Ready_out;
  logic        Busy_out;

  modport master (
    output SBox, KExp, Data_in, Enable, Ack_in,
    input  Data_out, Ready_out, Busy_out
  );

  modport slave (
    input  SBox, KExp, Data_in, Enable, Ack_in,
    output Data_out, Ready_out, Busy_out
  );
endinterface

// File: rtl/aes_cipher_state.sv
// Iterative AES forward cipher: initial AddRoundKey on load, then one full round per clock.
// Define AES_CIPHER_HOLD_EN to hold the result in a HOLD state until Ack_in is seen.
module aes_cipher_state #(
  parameter int Nb = 4,
  parameter int Nr = 10
) (
  input  logic              clk,
  input  logic              rst,
  aes_cipher_state_if.slave bus
);
  localparam int NBYTES = 4 * Nb;
  localparam int KWORDS = Nb * (Nr + 1);
  localparam int KIW    = $clog2(KWORDS);

`ifdef AES_CIPHER_HOLD_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ROUND = 2'd1, ST_HOLD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ROUND = 2'd1} state_t;
`endif

  state_t         state_reg, state_next;
  logic [3:0]     rnd_reg, rnd_next;
  logic           ready_reg, ready_next;
  logic [7:0]     s_reg  [0:NBYTES-1];
  logic [7:0]     s_next [0:NBYTES-1];

  logic [7:0]     sub_bytes  [0:NBYTES-1];
  logic [7:0]     shift_rows [0:NBYTES-1];
  logic [7:0]     mix_cols   [0:NBYTES-1];
  logic [7:0]     rk_round   [0:NBYTES-1];
  logic [7:0]     rk_zero    [0:NBYTES-1];
  logic [7:0]     load_vec   [0:NBYTES-1];
  logic [7:0]     mid_vec    [0:NBYTES-1];
  logic [7:0]     final_vec  [0:NBYTES-1];
  logic [KIW-1:0] key_base;
  logic           last_round;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round k reads key words Nb*k .. Nb*k+Nb-1, one per column.
  assign key_base   = KIW'(rnd_reg) * KIW'(Nb);
  assign last_round = (rnd_reg == 4'(Nr));

  generate
    for (genvar gi = 0; gi < Nb; gi++) begin : g_col
      for (genvar gj = 0; gj < 4; gj++) begin : g_row
        localparam int B = gj + 4 * gi;
        assign sub_bytes[B]  = bus.SBox[s_reg[B]];
        assign shift_rows[B] = sub_bytes[gj + 4 * ((gi + gj) % Nb)];
        assign mix_cols[B]   = xtime(shift_rows[4*gi + gj])
                             ^ xtime(shift_rows[4*gi + (gj + 1) % 4])
                             ^ shift_rows[4*gi + (gj + 1) % 4]
                             ^ shift_rows[4*gi + (gj + 2) % 4]
                             ^ shift_rows[4*gi + (gj + 3) % 4];
        assign rk_round[B]   = bus.KExp[key_base + KIW'(gi)][31 - 8*gj -: 8];
        assign rk_zero[B]    = bus.KExp[gi][31 - 8*gj -: 8];
        assign load_vec[B]   = bus.Data_in[B] ^ rk_zero[B];
        assign mid_vec[B]    = mix_cols[B] ^ rk_round[B];
        assign final_vec[B]  = shift_rows[B] ^ rk_round[B];
        assign bus.Data_out[B] = s_reg[B];
      end
    end
  endgenerate

  assign bus.Ready_out = ready_reg;
  assign bus.Busy_out  = (state_reg == ST_ROUND);

`ifndef AES_CIPHER_HOLD_EN
  logic ack_unused;
  assign ack_unused = bus.Ack_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      rnd_reg   <= 4'd0;
      ready_reg <= 1'b0;
      for (int i = 0; i < NBYTES; i++) begin
        s_reg[i] <= 8'h00;
      end
    end else begin
      state_reg <= state_next;
      rnd_reg   <= rnd_next;
      ready_reg <= ready_next;
      for (int i = 0; i < NBYTES; i++) begin
        s_reg[i] <= s_next[i];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.Enable) begin
          state_next = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (last_round) begin
`ifdef AES_CIPHER_HOLD_EN
          state_next = ST_HOLD;
`else
          state_next = ST_IDLE;
`endif
        end
      end
`ifdef AES_CIPHER_HOLD_EN
      ST_HOLD: begin
        // Ack and Enable together retire the result and start the next block.
        if (bus.Ack_in) begin
          state_next = bus.Enable ? ST_ROUND : ST_IDLE;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rnd_next   = rnd_reg;
    ready_next = ready_reg;
    for (int i = 0; i < NBYTES; i++) begin
      s_next[i] = s_reg[i];
    end
    case (state_reg)
      ST_IDLE: begin
        ready_next = 1'b0;
        if (bus.Enable) begin
          rnd_next = 4'd1;
          for (int i = 0; i < NBYTES; i++) begin
            s_next[i] = load_vec[i];
          end
        end
      end
      ST_ROUND: begin
        if (last_round) begin
          rnd_next   = 4'd0;
          ready_next = 1'b1;
          for (int i = 0; i < NBYTES; i++) begin
            s_next[i] = final_vec[i];
          end
        end else begin
          rnd_next = rnd_reg + 4'd1;
          for (int i = 0; i < NBYTES; i++) begin
            s_next[i] = mid_vec[i];
          end
        end
      end
`ifdef AES_CIPHER_HOLD_EN
      ST_HOLD: begin
        if (bus.Ack_in) begin
          ready_next = 1'b0;
          if (bus.Enable) begin
            rnd_next = 4'd1;
            for (int i = 0; i < NBYTES; i++) begin
              s_next[i] = load_vec[i];
            end
          end
        end
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_aes_cipher_state.sv
// Self-checking bench for aes_cipher_state: FIPS-197 vectors, back-to-back, reset abort,
// and randomized traffic against a whole-block AES reference model.
module tb_aes_cipher_state;
  localparam int NR = 10;
`ifdef AES_CIPHER_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif
  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KEY_C  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int gen_done = 0;
  logic [7:0] sbox_tbl [0:255];

  // reference model state
  int               pend = 0;
  bit               hold_m = 1'b0;
  bit               exp_ready = 1'b0;
  bit               data_known = 1'b0;
  logic [127:0]     exp_data = '0;
  logic [127:0]     result = '0;
  logic [59:0][31:0] kw;

  aes_cipher_state_if #(.Nb(4), .Nr(NR)) bus ();
  aes_cipher_state #(.Nb(4), .Nr(NR)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
    for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'(9'h11b) << (i - 8);
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] t;
    t = {b, b} << k;
    return t[15:8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
  endfunction

  function automatic logic [59:0][31:0] expand_key(input logic [255:0] key, input int nr);
    logic [59:0][31:0] w;
    logic [31:0] t;
    logic [7:0] rcon;
    int nk;
    nk = nr - 6;
    w = '0;
    rcon = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) w[i] = key[255 - 32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
          rcon = gmul(rcon, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = sub_word(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    return w;
  endfunction

  function automatic logic [7:0] mc_coef(input int d);
    return (d == 0) ? 8'h02 : (d == 1) ? 8'h03 : 8'h01;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [59:0][31:0] w, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] ct;
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8];
    for (int k = 0; k <= nr; k++) begin
      if (k > 0) begin
        for (int i = 0; i < 16; i++) s[i] = sbox_tbl[s[i]];
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) t[r + 4*c] = s[r + 4*((c + r) % 4)];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            if (k < nr) begin
              s[r + 4*c] = 8'h00;
              for (int j = 0; j < 4; j++) s[r + 4*c] ^= gmul(mc_coef((j - r + 4) % 4), t[j + 4*c]);
            end else s[r + 4*c] = t[r + 4*c];
          end
      end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r + 4*c] ^= w[4*k + c][31 - 8*r -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127 - 8*i -: 8] = s[i];
    return ct;
  endfunction

  function automatic logic [127:0] dout128();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = bus.Data_out[i];
    return v;
  endfunction

  function automatic logic [127:0] din128();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = bus.Data_in[i];
    return v;
  endfunction

  task automatic set_key(input logic [255:0] key);
    kw = expand_key(key, NR);
    for (int w = 0; w < 4 * (NR + 1); w++) bus.KExp[w] = kw[w];
  endtask

  task automatic set_data(input logic [127:0] pt);
    for (int i = 0; i < 16; i++) bus.Data_in[i] = pt[127 - 8*i -: 8];
  endtask

  task automatic run_block(input string name, input logic [255:0] key, input logic [127:0] pt,
                           input logic [127:0] ct);
    int cyc;
    @(negedge clk);
    set_key(key);
    set_data(pt);
    bus.Enable = 1'b1;
    cyc = 0;
    repeat (NR + 4) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) bus.Enable = 1'b0;
      if (bus.Ready_out) break;
    end
    check({name, "_latency"}, cyc, NR + 1);
    check({name, "_data"}, dout128(), ct);
    bus.Ack_in = 1'b1;
    @(posedge clk);
    #1;
    bus.Ack_in = 1'b0;
  endtask

  // Model step on each edge, DUT compared 1 time unit later.
  initial begin : compare_proc
    logic prev_ready;
    prev_ready = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        pend = 0; hold_m = 1'b0; exp_ready = 1'b0; exp_data = '0; data_known = 1'b1;
      end else if (pend != 0) begin
        pend--;
        if (pend == 0) begin
          exp_ready = 1'b1; exp_data = result; data_known = 1'b1; hold_m = HOLD_EN;
        end
      end else if (!(hold_m && !bus.Ack_in)) begin
        hold_m = 1'b0;
        exp_ready = 1'b0;
        if (bus.Enable) begin
          pend = NR; result = encrypt(din128(), kw, NR); data_known = 1'b0;
        end
      end
      #1;
      check("ready", bus.Ready_out, exp_ready);
      check("busy", bus.Busy_out, pend != 0);
      if (data_known) check("data_out", dout128(), exp_data);
      if (bus.Ready_out && !prev_ready) $display("block ready ct=%h t=%0t", dout128(), $time);
      prev_ready = bus.Ready_out;
    end
  end

  // Larger key sizes: Nr=12 (FIPS C.2) and Nr=14 (FIPS C.3).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_big
      localparam int GNR = 12 + 2 * gi;
      localparam logic [127:0] GCT = (gi == 0) ? 128'hdda97ca4864cdfe06eaf70a0ec0d7191
                                               : 128'h8ea2b7ca516745bfeafc49904b496089;
      aes_cipher_state_if #(.Nb(4), .Nr(GNR)) gbus ();
      aes_cipher_state #(.Nb(4), .Nr(GNR)) gdut (.clk(clk), .rst(rst), .bus(gbus));
      initial begin
        logic [59:0][31:0] gw;
        logic [127:0] got;
        int cyc;
        gbus.Enable = 1'b0;
        gbus.Ack_in = 1'b0;
        for (int i = 0; i < 16; i++) gbus.Data_in[i] = 8'h00;
        @(negedge rst);
        @(negedge clk);
        for (int i = 0; i < 256; i++) gbus.SBox[i] = sbox_tbl[i];
        gw = expand_key(KEY_C, GNR);
        for (int w = 0; w < 4 * (GNR + 1); w++) gbus.KExp[w] = gw[w];
        for (int i = 0; i < 16; i++) gbus.Data_in[i] = PT_C[127 - 8*i -: 8];
        gbus.Enable = 1'b1;
        cyc = 0;
        repeat (GNR + 4) begin
          @(posedge clk);
          #1;
          cyc++;
          if (cyc == 1) gbus.Enable = 1'b0;
          if (gbus.Ready_out) break;
        end
        for (int i = 0; i < 16; i++) got[127 - 8*i -: 8] = gbus.Data_out[i];
        check($sformatf("nr%0d_latency", GNR), cyc, GNR + 1);
        check($sformatf("nr%0d_data", GNR), got, GCT);
        gbus.Ack_in = 1'b1;
        gen_done++;
      end
    end
  endgenerate

  initial begin : main_proc
    logic [7:0] inv;
    logic [59:0][31:0] wb;
    int rdy_count, first_rdy, second_rdy;
    bit idle_ok;

    for (int a = 0; a < 256; a++) begin
      inv = (a == 0) ? 8'h00 : 8'h01;
      if (a != 0) repeat (254) inv = gmul(inv, 8'(a));
      sbox_tbl[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int i = 0; i < 256; i++) bus.SBox[i] = sbox_tbl[i];
    check("model_sbox_00", sbox_tbl[0], 8'h63);
    check("model_sbox_53", sbox_tbl[8'h53], 8'hed);
    wb = expand_key(KEY_B, NR);
    check("model_w43", wb[43], 32'hb6630ca6);
    check("model_appB", encrypt(PT_B, wb, NR), CT_B);

    bus.Enable = 1'b0;
    bus.Ack_in = 1'b0;
    set_data('0);
    set_key('0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_block("appB", KEY_B, PT_B, CT_B);
    run_block("c1", KEY_C, PT_C, CT_C1);
    wait (gen_done == 2);

    // Back-to-back: Enable held high, so pulses during ROUND must be ignored.
    @(negedge clk);
    set_key(KEY_C);
    set_data({$urandom, $urandom, $urandom, $urandom});
    bus.Enable = 1'b1;
    bus.Ack_in = 1'b1;
    rdy_count = 0; first_rdy = 0; second_rdy = 0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.Ready_out) begin
        rdy_count++;
        if (first_rdy == 0) first_rdy = cyc;
        else second_rdy = cyc;
      end
      if (cyc == 22) bus.Enable = 1'b0;
      set_data({$urandom, $urandom, $urandom, $urandom});
    end
    bus.Ack_in = 1'b0;
    check("b2b_pulses", rdy_count, 2);
    check("b2b_spacing", second_rdy - first_rdy, NR + 1);

    // Abort at round 5 with Enable also high on the reset edge.
    @(negedge clk);
    set_data(PT_C);
    bus.Enable = 1'b1;
    @(negedge clk);
    bus.Enable = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    bus.Enable = 1'b1;
    @(posedge clk);
    #1;
    check("rst_data", dout128(), '0);
    check("rst_ready", bus.Ready_out, 1'b0);
    check("rst_busy", bus.Busy_out, 1'b0);
    rst = 1'b0;
    bus.Enable = 1'b0;
    run_block("rst_recover", KEY_C, PT_C, CT_C1);

`ifdef AES_CIPHER_HOLD_EN
    @(negedge clk);
    set_data(PT_B);
    set_key(KEY_B);
    bus.Enable = 1'b1;
    @(negedge clk);
    bus.Enable = 1'b0;
    repeat (NR + 20) @(negedge clk);
    bus.Ack_in = 1'b1;
    bus.Enable = 1'b1;
    set_data({$urandom, $urandom, $urandom, $urandom});
    @(negedge clk);
    bus.Ack_in = 1'b0;
    bus.Enable = 1'b0;
    repeat (NR + 3) @(negedge clk);
    bus.Ack_in = 1'b1;
    @(negedge clk);
    bus.Ack_in = 1'b0;
`endif

    // Random traffic: new key per episode, random Enable/Ack_in/Data_in and rare resets.
    for (int ep = 0; ep < 25; ep++) begin
      bus.Enable = 1'b0;
      bus.Ack_in = 1'b1;
      rst = 1'b0;
      idle_ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!bus.Busy_out && !bus.Ready_out) begin
          idle_ok = 1'b1;
          break;
        end
      end
      check("idle_wait", idle_ok, 1'b1);
      set_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      repeat (40) begin
        @(negedge clk);
        rst = ($urandom_range(0, 99) < 2);
        bus.Enable = ($urandom_range(0, 2) == 0);
        bus.Ack_in = 1'($urandom_range(0, 1));
        set_data({$urandom, $urandom, $urandom, $urandom});
      end
    end
    @(negedge clk);
    rst = 1'b0;
    bus.Enable = 1'b0;
    bus.Ack_in = 1'b1;
    repeat (NR + 4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
